bit_serializer: RTL



---
 rtl/fsm_pkg.sv | 11 +
 rtl/bit_serializer.sv | 102 ++++++++++
 2 files changed

// File: rtl/fsm_pkg.sv
// Shared types and constants for the bit_serializer -> fsm_1100 stimulus path.
package fsm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] PATTERN_1100 = 4'b1100;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on a valid/ready handshake and
// emits one registered bit per enabled clock, back-to-back words without a bubble.
module bit_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy
);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready;
  // din/din_valid must stay stable until then, and din_ready never waits on din_valid.

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             vld_q, vld_d;
  logic             pend_q, pend_d;
  logic             last;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last      = (cnt_q == '0);
  assign din_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && last && bit_en));
  assign accept    = din_valid && din_ready;

  // pend_q marks a first bit loaded while bit_en was low; it is shown once enabled
  // instead of being skipped by the next shift.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    vld_d   = 1'b0;
    pend_d  = pend_q;
    if (accept) begin
      sreg_d  = drop(din);
      bit_d   = head(din);
      cnt_d   = CNT_LAST;
      state_d = SHIFT;
      vld_d   = bit_en;
      pend_d  = !bit_en;
    end else if (state_q == SHIFT && bit_en) begin
      if (pend_q) begin
        vld_d  = 1'b1;
        pend_d = 1'b0;
      end else if (last) begin
        state_d = IDLE;
        sreg_d  = '0;
        bit_d   = 1'b0;
      end else begin
        bit_d  = head(sreg_q);
        sreg_d = drop(sreg_q);
        cnt_d  = cnt_q - 1'b1;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      pend_q  <= pend_d;
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = vld_q;
  assign busy      = (state_q == SHIFT);

endmodule
